periph_responder: RTL

PERIPH_RESPONDER -- requirements
Module: periph_responder

---
 rtl/periph_responder.sv | 129 ++++++++++++
 1 files changed

// File: rtl/periph_responder.sv
// Memory-mapped peripheral block: 32-bit reload timer with sticky interrupt, LED and
// seven-segment registers, optional free-running systick (enabled by PERIPH_SYSTICK_EN).
module periph_responder #(
  parameter logic [31:0] BASE_ADDR = 32'h4000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] Address,
  input  logic [31:0] Write_data,
  input  logic        MemRead,
  input  logic        MemWrite,
  output logic [31:0] Read_data,
  output logic        irq,
  output logic [7:0]  led,
  output logic [11:0] digits
);

  localparam logic [2:0] IDX_TH      = 3'd0;
  localparam logic [2:0] IDX_TL      = 3'd1;
  localparam logic [2:0] IDX_TCON    = 3'd2;
  localparam logic [2:0] IDX_LED     = 3'd3;
  localparam logic [2:0] IDX_DIGITS  = 3'd4;
  localparam logic [2:0] IDX_SYSTICK = 3'd5;

  logic [31:0] th_q, th_d;
  logic [31:0] tl_q, tl_d;
  logic [2:0]  tcon_q, tcon_d;
  logic [7:0]  led_q, led_d;
  logic [11:0] digits_q, digits_d;
  logic [31:0] rdata_q, rdata_d;
  logic [31:0] systick_val;

  // Word-granular decode relative to the base; byte lane bits are ignored.
  logic [29:0] word_off;
  logic [2:0]  idx;
  logic        hit;
  logic [1:0]  unused_lane;

  assign word_off    = Address[31:2] - BASE_ADDR[31:2];
  assign idx         = word_off[2:0];
  assign hit         = (word_off[29:3] == '0) && (idx <= IDX_SYSTICK);
  assign unused_lane = Address[1:0];

  logic wr_th, wr_tl, wr_tcon, wr_led, wr_digits;

  assign wr_th     = MemWrite && hit && (idx == IDX_TH);
  assign wr_tl     = MemWrite && hit && (idx == IDX_TL);
  assign wr_tcon   = MemWrite && hit && (idx == IDX_TCON);
  assign wr_led    = MemWrite && hit && (idx == IDX_LED);
  assign wr_digits = MemWrite && hit && (idx == IDX_DIGITS);

`ifdef PERIPH_SYSTICK_EN
  logic [31:0] systick_q, systick_d;

  assign systick_d   = systick_q + 32'd1;
  assign systick_val = systick_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) systick_q <= '0;
    else        systick_q <= systick_d;
  end
`else
  assign systick_val = '0;
`endif

  // Timer: a CPU write to TL suppresses that cycle's count/reload entirely;
  // a TCON write overrides only the control/status bits, so TL keeps counting.
  always_comb begin
    tl_d   = tl_q;
    tcon_d = tcon_q;
    if (wr_tl) begin
      tl_d = Write_data;
    end else if (tcon_q[0]) begin
      if (tl_q == 32'hFFFF_FFFF) begin
        tl_d = th_q;
        if (tcon_q[1]) tcon_d[2] = 1'b1;
      end else begin
        tl_d = tl_q + 32'd1;
      end
    end
    if (wr_tcon) tcon_d = Write_data[2:0];
  end

  always_comb begin
    th_d     = wr_th     ? Write_data        : th_q;
    led_d    = wr_led    ? Write_data[7:0]   : led_q;
    digits_d = wr_digits ? Write_data[11:0]  : digits_q;
  end

  // Read mux samples pre-edge register values, giving read-before-write ordering.
  always_comb begin
    rdata_d = '0;
    if (MemRead && hit) begin
      unique case (idx)
        IDX_TH:      rdata_d = th_q;
        IDX_TL:      rdata_d = tl_q;
        IDX_TCON:    rdata_d = {29'd0, tcon_q};
        IDX_LED:     rdata_d = {24'd0, led_q};
        IDX_DIGITS:  rdata_d = {20'd0, digits_q};
        IDX_SYSTICK: rdata_d = systick_val;
        default:     rdata_d = '0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      th_q     <= '0;
      tl_q     <= '0;
      tcon_q   <= '0;
      led_q    <= '0;
      digits_q <= '0;
      rdata_q  <= '0;
    end else begin
      th_q     <= th_d;
      tl_q     <= tl_d;
      tcon_q   <= tcon_d;
      led_q    <= led_d;
      digits_q <= digits_d;
      rdata_q  <= rdata_d;
    end
  end

  assign Read_data = rdata_q;
  assign irq       = tcon_q[2];
  assign led       = led_q;
  assign digits    = digits_q;

endmodule
